ahb_mtx_dec_param: RTL and testbench

Parametrised AHB bus-matrix input-stage decoder. Maps each slave-side input port transfer to one of NUM_PORTS output stages, or to an integrated default slave for unmapped addresses. It adds programmable address regions, a remap mode, a two-cycle ERROR default-slave FSM and a saturating unmapped-access counter. It sits between a matrix input stage and its output-stage bus switches.

---
 rtl/ahb_mtx_pkg.sv | 18 +
 rtl/ahb_mtx_dft_slv_fsm.sv | 72 +++++++
 rtl/ahb_mtx_dec_param.sv | 111 +++++++++++
 tb/tb_ahb_mtx_dec_param.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_mtx_pkg.sv
// Shared constants and types for the AHB bus-matrix input-stage decoder.
package ahb_mtx_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DFT_IDLE = 2'd0,
        DFT_ERR1 = 2'd1,
        DFT_ERR2 = 2'd2
    } dft_state_t;

endpackage

// File: rtl/ahb_mtx_dft_slv_fsm.sv
// Default slave: two-cycle ERROR response for unmapped NONSEQ/SEQ transfers
// plus a saturating count of those transfers.
//
//   state    | meaning
//   DFT_IDLE | no error pending, zero-wait OKAY
//   DFT_ERR1 | first ERROR cycle, HREADYOUT low
//   DFT_ERR2 | second ERROR cycle, HREADYOUT high
module ahb_mtx_dft_slv_fsm
    import ahb_mtx_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             accept,
    output logic             ready,
    output logic [1:0]       resp,
    output logic [CNT_W-1:0] unmapped_cnt
);

    dft_state_t state;
    dft_state_t state_nxt;
    logic       enter_err;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= DFT_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b1;
        resp      = HRESP_OKAY;
        enter_err = 1'b0;
        case (state)
            DFT_IDLE: begin
                if (accept) begin
                    state_nxt = DFT_ERR1;
                    enter_err = 1'b1;
                end
            end
            DFT_ERR1: begin
                ready     = 1'b0;
                resp      = HRESP_ERROR;
                state_nxt = DFT_ERR2;
            end
            DFT_ERR2: begin
                resp = HRESP_ERROR;
                if (accept) begin
                    state_nxt = DFT_ERR1;
                    enter_err = 1'b1;
                end else begin
                    state_nxt = DFT_IDLE;
                end
            end
            default: state_nxt = DFT_IDLE;
        endcase
    end

    // Saturates at all-ones so a runaway master cannot wrap the count.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            unmapped_cnt <= '0;
        end else if (enter_err && (unmapped_cnt != {CNT_W{1'b1}})) begin
            unmapped_cnt <= unmapped_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ahb_mtx_dec_param.sv
// Bus-matrix input-stage decoder: routes each transfer to one of NUM_PORTS
// output stages or to the integrated default slave, and muxes the response.
module ahb_mtx_dec_param
    import ahb_mtx_pkg::*;
#(
    parameter int                    NUM_PORTS   = 4,
    parameter logic [NUM_PORTS*22-1:0] REGION_BASE = {NUM_PORTS{22'h0}},
    parameter logic [NUM_PORTS*22-1:0] REGION_MASK = {NUM_PORTS{22'h3FFFC0}},
    parameter int                    REMAP_SRC   = 0,
    parameter int                    REMAP_DST   = 1,
    parameter int                    CNT_W       = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      HREADYS,
    input  logic                      sel_dec,
    input  logic [21:0]               decode_addr_dec,
    input  logic [1:0]                trans_dec,
    input  logic                      remap,
    input  logic [NUM_PORTS-1:0]      active_dec_i,
    input  logic [NUM_PORTS-1:0]      readyout_dec_i,
    input  logic [2*NUM_PORTS-1:0]    resp_dec_i,
    input  logic [32*NUM_PORTS-1:0]   rdata_dec_i,
    input  logic [32*NUM_PORTS-1:0]   ruser_dec_i,
    output logic [NUM_PORTS-1:0]      sel_dec_o,
    output logic                      active_dec,
    output logic                      HREADYOUTS,
    output logic [1:0]                HRESPS,
    output logic [31:0]               HRDATAS,
    output logic [31:0]               HRUSERS,
    output logic [CNT_W-1:0]          unmapped_cnt
);

    localparam int               IDX_W   = $clog2(NUM_PORTS + 1);
    localparam logic [IDX_W-1:0] DFT_IDX = IDX_W'(NUM_PORTS);

    logic [IDX_W-1:0] dec_port;
    logic [IDX_W-1:0] addr_port;
    logic [IDX_W-1:0] data_port;
    logic             hit;
    logic             dft_sel;
    logic             dft_accept;
    logic             dft_ready;
    logic [1:0]       dft_resp;

    // Lowest matching region wins; remap only redirects the winning region.
    always_comb begin
        dec_port = DFT_IDX;
        hit      = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (!hit && ((decode_addr_dec & REGION_MASK[i*22 +: 22]) == REGION_BASE[i*22 +: 22])) begin
                dec_port = IDX_W'(i);
                hit      = 1'b1;
            end
        end
        if (remap && hit && (dec_port == IDX_W'(REMAP_SRC))) begin
            dec_port = IDX_W'(REMAP_DST);
        end
    end

    // Parking on IDLE keeps the output-stage switch from toggling needlessly.
    assign addr_port = (trans_dec == HTRANS_IDLE) ? data_port : dec_port;
    assign dft_sel   = sel_dec && (addr_port == DFT_IDX);
    assign dft_accept = dft_sel && HREADYS && trans_dec[1];

    always_comb begin
        sel_dec_o  = '0;
        active_dec = 1'b1;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (addr_port == IDX_W'(i)) begin
                sel_dec_o[i] = sel_dec;
                active_dec   = active_dec_i[i];
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            data_port <= '0;
        end else if (HREADYS) begin
            data_port <= addr_port;
        end
    end

    always_comb begin
        HREADYOUTS = dft_ready;
        HRESPS     = dft_resp;
        HRDATAS    = '0;
        HRUSERS    = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (data_port == IDX_W'(i)) begin
                HREADYOUTS = readyout_dec_i[i];
                HRESPS     = resp_dec_i[i*2 +: 2];
                HRDATAS    = rdata_dec_i[i*32 +: 32];
                HRUSERS    = ruser_dec_i[i*32 +: 32];
            end
        end
    end

    ahb_mtx_dft_slv_fsm #(
        .CNT_W (CNT_W)
    ) u_dft_slv (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .accept       (dft_accept),
        .ready        (dft_ready),
        .resp         (dft_resp),
        .unmapped_cnt (unmapped_cnt)
    );

endmodule

// File: tb/tb_ahb_mtx_dec_param.sv
// Randomized and directed bench for ahb_mtx_dec_param against a
// transfer-level reference model of address/data phases.
module tb_ahb_mtx_dec_param;

    localparam int NP      = 4;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [NP*22-1:0] BASE = {22'h000100, 22'h000100, 22'h000040, 22'h000000};
    localparam logic [NP*22-1:0] MASK = {22'h3FFF00, 22'h3FFFC0, 22'h3FFFC0, 22'h3FFFC0};
    localparam logic [21:0] A_UNM = 22'h3C0000;

    logic              hclk = 1'b0;
    logic              hresetn = 1'b0;
    logic              hreadys = 1'b0;
    logic              sel_dec = 1'b0;
    logic [21:0]       decode_addr_dec = '0;
    logic [1:0]        trans_dec = '0;
    logic              remap = 1'b0;
    logic [NP-1:0]     active_dec_i = '0;
    logic [NP-1:0]     readyout_dec_i = '0;
    logic [2*NP-1:0]   resp_dec_i = '0;
    logic [32*NP-1:0]  rdata_dec_i = '0;
    logic [32*NP-1:0]  ruser_dec_i = '0;
    logic [NP-1:0]     sel_dec_o;
    logic              active_dec;
    logic              hreadyouts;
    logic [1:0]        hresps;
    logic [31:0]       hrdatas;
    logic [31:0]       hrusers;
    logic [CNT_W-1:0]  unmapped_cnt;

    ahb_mtx_dec_param #(
        .NUM_PORTS   (NP),
        .REGION_BASE (BASE),
        .REGION_MASK (MASK),
        .REMAP_SRC   (0),
        .REMAP_DST   (1),
        .CNT_W       (CNT_W)
    ) dut (
        .HCLK            (hclk),
        .HRESETn         (hresetn),
        .HREADYS         (hreadys),
        .sel_dec         (sel_dec),
        .decode_addr_dec (decode_addr_dec),
        .trans_dec       (trans_dec),
        .remap           (remap),
        .active_dec_i    (active_dec_i),
        .readyout_dec_i  (readyout_dec_i),
        .resp_dec_i      (resp_dec_i),
        .rdata_dec_i     (rdata_dec_i),
        .ruser_dec_i     (ruser_dec_i),
        .sel_dec_o       (sel_dec_o),
        .active_dec      (active_dec),
        .HREADYOUTS      (hreadyouts),
        .HRESPS          (hresps),
        .HRDATAS         (hrdatas),
        .HRUSERS         (hrusers),
        .unmapped_cnt    (unmapped_cnt)
    );

    always #5 hclk = ~hclk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: region table, slave responses, and transfer state.
    logic [21:0] r_base [NP] = '{22'h000000, 22'h000040, 22'h000100, 22'h000100};
    logic [21:0] r_mask [NP] = '{22'h3FFFC0, 22'h3FFFC0, 22'h3FFFC0, 22'h3FFF00};
    logic        m_active [NP];
    logic        m_ready  [NP];
    logic [1:0]  m_resp   [NP];
    logic [31:0] m_rdata  [NP];
    logic [31:0] m_ruser  [NP];
    int m_data_port = 0;    // NP means the default slave owns the data phase
    int m_err_phase = 0;    // 0 none, 1 first error cycle, 2 second error cycle
    int m_cnt = 0;
    int m_ap = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_decode(input logic [21:0] a, input logic rm);
        int r = NP;
        for (int i = NP - 1; i >= 0; i--)
            if ((a & r_mask[i]) == r_base[i]) r = i;
        if (rm && r == 0) r = 1;
        return r;
    endfunction

    task automatic model_reset();
        m_data_port = 0;
        m_err_phase = 0;
        m_cnt = 0;
    endtask

    task automatic drive(input logic [21:0] a, input logic [1:0] t, input logic s,
                         input logic rdy, input logic rm);
        decode_addr_dec = a;
        trans_dec = t;
        sel_dec = s;
        hreadys = rdy;
        remap = rm;
        for (int i = 0; i < NP; i++) begin
            m_active[i] = 1'($urandom_range(1));
            m_ready[i]  = 1'($urandom_range(1));
            m_resp[i]   = 2'($urandom_range(3));
            m_rdata[i]  = $urandom;
            m_ruser[i]  = $urandom;
            active_dec_i[i]          = m_active[i];
            readyout_dec_i[i]        = m_ready[i];
            resp_dec_i[i*2 +: 2]     = m_resp[i];
            rdata_dec_i[i*32 +: 32]  = m_rdata[i];
            ruser_dec_i[i*32 +: 32]  = m_ruser[i];
        end
    endtask

    task automatic check_outputs();
        logic [NP-1:0] e_sel;
        logic          e_act;
        logic          e_rdy;
        logic [1:0]    e_resp;
        logic [31:0]   e_rd;
        logic [31:0]   e_ru;
        m_ap = (trans_dec == 2'b00) ? m_data_port : ref_decode(decode_addr_dec, remap);
        e_sel = '0;
        e_act = 1'b1;
        if (m_ap < NP) begin
            e_sel = NP'(sel_dec) << m_ap;
            e_act = m_active[m_ap];
        end
        if (m_data_port == NP) begin
            e_rdy  = (m_err_phase != 1);
            e_resp = (m_err_phase != 0) ? 2'b01 : 2'b00;
            e_rd   = '0;
            e_ru   = '0;
        end else begin
            e_rdy  = m_ready[m_data_port];
            e_resp = m_resp[m_data_port];
            e_rd   = m_rdata[m_data_port];
            e_ru   = m_ruser[m_data_port];
        end
        chk_val("sel_dec_o", 32'(sel_dec_o), 32'(e_sel));
        chk_val("active_dec", 32'(active_dec), 32'(e_act));
        chk_val("hreadyouts", 32'(hreadyouts), 32'(e_rdy));
        chk_val("hresps", 32'(hresps), 32'(e_resp));
        chk_val("hrdatas", hrdatas, e_rd);
        chk_val("hrusers", hrusers, e_ru);
        chk_val("unmapped_cnt", 32'(unmapped_cnt), 32'(m_cnt));
    endtask

    // One bus cycle: drive at negedge, check, then advance the model to the next edge.
    task automatic step(input logic [21:0] a, input logic [1:0] t, input logic s,
                        input logic rdy, input logic rm);
        bit acc;
        @(negedge hclk);
        drive(a, t, s, rdy, rm);
        #1;
        check_outputs();
        acc = hreadys && sel_dec && (m_ap == NP) && trans_dec[1];
        if (m_err_phase == 1) begin
            m_err_phase = 2;
        end else if (acc) begin
            m_err_phase = 1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end else begin
            m_err_phase = 0;
        end
        if (hreadys) m_data_port = m_ap;
    endtask

    initial begin
        int base_cnt;
        logic [21:0] a;
        logic rm;

        drive(22'h000010, 2'b00, 1'b1, 1'b1, 1'b0);
        #2;
        model_reset();
        check_outputs();
        chk_val("rst_sel_park", 32'(sel_dec_o), 32'h1);
        chk_val("rst_ready", 32'(hreadyouts), 32'(readyout_dec_i[0]));
        #20;
        hresetn = 1'b1;

        // Region 2 select and its data phase one cycle later.
        step(22'h000100, 2'b10, 1'b1, 1'b1, 1'b0);
        chk_val("t1_sel", 32'(sel_dec_o), 32'h4);
        step(22'h000010, 2'b00, 1'b0, 1'b1, 1'b0);
        chk_val("t1_rdata", hrdatas, m_rdata[2]);
        chk_val("t1_overlap_low", 32'(ref_decode(22'h000120, 1'b0)), 32'd2);

        // Single unmapped access: two ERROR cycles then OKAY.
        base_cnt = m_cnt;
        step(A_UNM, 2'b10, 1'b1, 1'b1, 1'b0);
        step(A_UNM, 2'b00, 1'b1, 1'b0, 1'b0);
        chk_val("t2_c1_ready", 32'(hreadyouts), 32'd0);
        chk_val("t2_c1_resp", 32'(hresps), 32'd1);
        chk_val("t2_rdata", hrdatas, 32'd0);
        chk_val("t2_cnt", 32'(unmapped_cnt), 32'(base_cnt + 1));
        step(A_UNM, 2'b00, 1'b1, 1'b1, 1'b0);
        chk_val("t2_c2_ready", 32'(hreadyouts), 32'd1);
        chk_val("t2_c2_resp", 32'(hresps), 32'd1);
        step(A_UNM, 2'b00, 1'b1, 1'b1, 1'b0);
        chk_val("t2_okay", 32'(hresps), 32'd0);

        // Back-to-back unmapped accesses re-enter the first error cycle directly.
        base_cnt = m_cnt;
        step(A_UNM, 2'b10, 1'b1, 1'b1, 1'b0);
        step(A_UNM, 2'b10, 1'b1, 1'b0, 1'b0);
        step(A_UNM, 2'b11, 1'b1, 1'b1, 1'b0);
        step(A_UNM, 2'b00, 1'b1, 1'b0, 1'b0);
        chk_val("t3_reenter_ready", 32'(hreadyouts), 32'd0);
        chk_val("t3_reenter_resp", 32'(hresps), 32'd1);
        chk_val("t3_cnt", 32'(unmapped_cnt), 32'(base_cnt + 2));
        step(A_UNM, 2'b00, 1'b1, 1'b1, 1'b0);

        // Remap redirects region 0 to port 1.
        step(22'h000010, 2'b10, 1'b1, 1'b1, 1'b1);
        chk_val("t4_remap_on", 32'(sel_dec_o), 32'h2);
        step(22'h000010, 2'b10, 1'b1, 1'b1, 1'b0);
        chk_val("t4_remap_off", 32'(sel_dec_o), 32'h1);

        // Stalled data phase holds the selected port; IDLE parks on it.
        step(22'h000180, 2'b10, 1'b1, 1'b1, 1'b0);
        chk_val("t5_sel3", 32'(sel_dec_o), 32'h8);
        step(22'h000040, 2'b10, 1'b1, 1'b0, 1'b0);
        chk_val("t5_hold_a", hrdatas, m_rdata[3]);
        step(22'h000100, 2'b10, 1'b1, 1'b0, 1'b0);
        chk_val("t5_hold_b", hrdatas, m_rdata[3]);
        step(22'h000010, 2'b00, 1'b1, 1'b1, 1'b0);
        chk_val("t5_park", 32'(sel_dec_o), 32'h8);

        // Randomized traffic.
        rm = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            if (n % 32 == 0) rm = 1'($urandom_range(1));
            case ($urandom_range(5))
                0: a = 22'($urandom_range(63));
                1: a = 22'h000040 + 22'($urandom_range(63));
                2: a = 22'h000100 + 22'($urandom_range(63));
                3: a = 22'h000140 + 22'($urandom_range(191));
                4: a = 22'($urandom);
                default: a = A_UNM;
            endcase
            step(a, 2'($urandom_range(3)), ($urandom_range(9) != 0),
                 ($urandom_range(3) != 0), rm);
        end

        // 300 unmapped accesses saturate the counter.
        step(A_UNM, 2'b10, 1'b1, 1'b1, 1'b0);
        for (int n = 0; n < 299; n++) begin
            step(A_UNM, 2'b10, 1'b1, 1'b0, 1'b0);
            step(A_UNM, 2'b11, 1'b1, 1'b1, 1'b0);
        end
        step(A_UNM, 2'b10, 1'b1, 1'b0, 1'b0);
        chk_val("t6_saturate", 32'(unmapped_cnt), 32'(CNT_MAX));
        chk_val("t6_err1_ready", 32'(hreadyouts), 32'd0);

        // Asynchronous reset while in the first error cycle.
        #1;
        hresetn = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk_val("t6_rst_cnt", 32'(unmapped_cnt), 32'd0);
        chk_val("t6_rst_ready", 32'(hreadyouts), 32'(m_ready[0]));
        @(negedge hclk);
        hresetn = 1'b1;
        step(22'h000040, 2'b10, 1'b1, 1'b1, 1'b0);
        step(22'h000040, 2'b00, 1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
